// File: rtl/pwl_sweep_pkg.sv
// rtl/pwl_sweep_pkg.sv - shared register indices, sweep word layout and state type
package pwl_sweep_pkg;

  // Register selector, low two bits of wr_addr
  localparam logic [1:0] REG_PERIOD = 2'd0;
  localparam logic [1:0] REG_AMP    = 2'd1;
  localparam logic [1:0] REG_PSWEEP = 2'd2;
  localparam logic [1:0] REG_ASWEEP = 2'd3;

  // Sweep word is {en, dir, rate[RATE_BITS-1:0]}
  function automatic int sweep_en_bit(input int rate_bits);
    return rate_bits + 1;
  endfunction

  function automatic int sweep_dir_bit(input int rate_bits);
    return rate_bits;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pwl_sweep_step.sv
// rtl/pwl_sweep_step.sv - one-field sweep step (value/counter update); honours PWL_SWEEP_AUTO_DISABLE_EN
module pwl_sweep_step
  import pwl_sweep_pkg::*;
#(
  parameter int VALUE_BITS = 13,
  parameter int RATE_BITS  = 8
) (
  input  logic [VALUE_BITS-1:0] value,
  input  logic [RATE_BITS-1:0]  counter,
  input  logic [RATE_BITS+1:0]  sweep,
  output logic [VALUE_BITS-1:0] next_value,
  output logic [RATE_BITS-1:0]  next_counter,
  output logic                  saturated,
  output logic                  next_en
);

  localparam int EN_BIT  = sweep_en_bit(RATE_BITS);
  localparam int DIR_BIT = sweep_dir_bit(RATE_BITS);
  localparam logic [VALUE_BITS-1:0] VMAX = '1;
  localparam logic [VALUE_BITS-1:0] VONE = VALUE_BITS'(1);

  logic                 en;
  logic                 dir;
  logic [RATE_BITS-1:0] rate;

  assign en   = sweep[EN_BIT];
  assign dir  = sweep[DIR_BIT];
  assign rate = sweep[RATE_BITS-1:0];

  // Step the value when the counter reaches rate, otherwise advance the counter.
  // saturated means this step ends at the limit (including a step held at the limit).
  always_comb begin
    next_value   = value;
    next_counter = counter;
    saturated    = 1'b0;
    if (en) begin
      if (counter == rate) begin
        next_counter = '0;
        if (!dir) begin
          if (value != VMAX) next_value = value + VONE;
          saturated = (value == VMAX) || (value == VMAX - VONE);
        end else begin
          if (value != '0) next_value = value - VONE;
          saturated = (value == '0) || (value == VONE);
        end
      end else begin
        next_counter = counter + 1'b1;
      end
    end
  end

`ifdef PWL_SWEEP_AUTO_DISABLE_EN
  assign next_en = en & ~saturated;
`else
  assign next_en = en;
`endif

endmodule

// File: rtl/pwl_sweep_engine.sv
// rtl/pwl_sweep_engine.sv - time-multiplexed period/amp sweep engine; optional PWL_SWEEP_AUTO_DISABLE_EN
module pwl_sweep_engine
  import pwl_sweep_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int PERIOD_BITS  = 13,
  parameter int AMP_BITS     = 6,
  parameter int RATE_BITS    = 8,
  parameter int PRESCALE     = 256
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [$clog2(NUM_CHANNELS)+1:0]     wr_addr,
  input  logic [15:0]                         wr_data,
  input  logic                                ovr_clr,
  output logic [NUM_CHANNELS*PERIOD_BITS-1:0] periods,
  output logic [NUM_CHANNELS*AMP_BITS-1:0]    amps,
  output logic                                busy,
  output logic                                pass_done,
  output logic                                overrun
);

  localparam int CH_BITS  = $clog2(NUM_CHANNELS);
  localparam int PTR_BITS = (CH_BITS > 0) ? CH_BITS : 1;
  localparam int PS_BITS  = $clog2(PRESCALE);
  localparam int SW_BITS  = RATE_BITS + 2;
  localparam int EN_BIT   = sweep_en_bit(RATE_BITS);
  localparam logic [PTR_BITS-1:0] LAST_PTR = PTR_BITS'(NUM_CHANNELS - 1);
  localparam logic [PS_BITS-1:0]  PS_LAST  = PS_BITS'(PRESCALE - 1);

  state_t              state;
  logic [PTR_BITS-1:0] ptr;
  logic [PS_BITS-1:0]  presc;
  logic                tick;

  logic [PERIOD_BITS-1:0] period_r [NUM_CHANNELS];
  logic [AMP_BITS-1:0]    amp_r    [NUM_CHANNELS];
  logic [SW_BITS-1:0]     psweep_r [NUM_CHANNELS];
  logic [SW_BITS-1:0]     asweep_r [NUM_CHANNELS];
  logic [RATE_BITS-1:0]   pcnt_r   [NUM_CHANNELS];
  logic [RATE_BITS-1:0]   acnt_r   [NUM_CHANNELS];

  logic [PTR_BITS-1:0]     wr_ch;
  logic [1:0]              wr_reg;
  logic [NUM_CHANNELS-1:0] p_hit;
  logic [NUM_CHANNELS-1:0] a_hit;
  logic [NUM_CHANNELS-1:0] proc;

  logic [PERIOD_BITS-1:0] p_next;
  logic [RATE_BITS-1:0]   p_cnt_next;
  logic                   p_sat;
  logic                   p_en_next;
  logic [AMP_BITS-1:0]    a_next;
  logic [RATE_BITS-1:0]   a_cnt_next;
  logic                   a_sat;
  logic                   a_en_next;
  logic                   unused_ok;

  assign tick   = (presc == PS_LAST);
  assign wr_ch  = PTR_BITS'(wr_addr >> 2);
  assign wr_reg = wr_addr[1:0];

  // Saturation flags are informational here; high wr_data bits are ignored.
  assign unused_ok = ^{p_sat, a_sat, wr_data};

  // Decode which channel fields are written and which channel is being swept this cycle
  always_comb begin
    p_hit = '0;
    a_hit = '0;
    proc  = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      p_hit[i] = wr_en && (wr_ch == PTR_BITS'(i)) &&
                 ((wr_reg == REG_PERIOD) || (wr_reg == REG_PSWEEP));
      a_hit[i] = wr_en && (wr_ch == PTR_BITS'(i)) &&
                 ((wr_reg == REG_AMP) || (wr_reg == REG_ASWEEP));
      proc[i]  = (state == RUN) && (ptr == PTR_BITS'(i));
    end
  end

  pwl_sweep_step #(
    .VALUE_BITS (PERIOD_BITS),
    .RATE_BITS  (RATE_BITS)
  ) u_period_step (
    .value        (period_r[ptr]),
    .counter      (pcnt_r[ptr]),
    .sweep        (psweep_r[ptr]),
    .next_value   (p_next),
    .next_counter (p_cnt_next),
    .saturated    (p_sat),
    .next_en      (p_en_next)
  );

  pwl_sweep_step #(
    .VALUE_BITS (AMP_BITS),
    .RATE_BITS  (RATE_BITS)
  ) u_amp_step (
    .value        (amp_r[ptr]),
    .counter      (acnt_r[ptr]),
    .sweep        (asweep_r[ptr]),
    .next_value   (a_next),
    .next_counter (a_cnt_next),
    .saturated    (a_sat),
    .next_en      (a_en_next)
  );

  // Register file: a bus write to a field always beats the sweep update of that field
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        period_r[i] <= '0;
        amp_r[i]    <= '0;
        psweep_r[i] <= '0;
        asweep_r[i] <= '0;
        pcnt_r[i]   <= '0;
        acnt_r[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (p_hit[i]) begin
          if (wr_reg == REG_PERIOD) period_r[i] <= wr_data[PERIOD_BITS-1:0];
          else                      psweep_r[i] <= wr_data[SW_BITS-1:0];
          pcnt_r[i] <= '0;
        end else if (proc[i]) begin
          period_r[i]         <= p_next;
          pcnt_r[i]           <= p_cnt_next;
          psweep_r[i][EN_BIT] <= p_en_next;
        end

        if (a_hit[i]) begin
          if (wr_reg == REG_AMP) amp_r[i]    <= wr_data[AMP_BITS-1:0];
          else                   asweep_r[i] <= wr_data[SW_BITS-1:0];
          acnt_r[i] <= '0;
        end else if (proc[i]) begin
          amp_r[i]            <= a_next;
          acnt_r[i]           <= a_cnt_next;
          asweep_r[i][EN_BIT] <= a_en_next;
        end
      end
    end
  end

  // Prescaler and pass sequencer with registered busy/pass_done/overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      state     <= IDLE;
      ptr       <= '0;
      busy      <= 1'b0;
      pass_done <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      presc     <= tick ? '0 : presc + 1'b1;
      pass_done <= 1'b0;

      // A tick arriving mid-pass is dropped; a set beats a same-cycle clear
      if (tick && (state == RUN)) overrun <= 1'b1;
      else if (ovr_clr)           overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (tick) begin
            state <= RUN;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (ptr == LAST_PTR) begin
            state     <= IDLE;
            busy      <= 1'b0;
            pass_done <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Flatten per-channel registers, channel 0 in the LSBs
  always_comb begin
    periods = '0;
    amps    = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      periods[i*PERIOD_BITS +: PERIOD_BITS] = period_r[i];
      amps[i*AMP_BITS +: AMP_BITS]          = amp_r[i];
    end
  end

endmodule

// File: tb/tb_pwl_sweep_engine.sv
// tb/tb_pwl_sweep_engine.sv - self-checking bench for pwl_sweep_engine
module tb_pwl_sweep_engine;

  localparam int N    = 4;
  localparam int PB   = 13;
  localparam int AB   = 6;
  localparam int RB   = 8;
  localparam int P    = 16;
  localparam int PMAX = 8191;
  localparam int AMAX = 63;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [3:0]    wr_addr = '0;
  logic [15:0]   wr_data = '0;
  logic          ovr_clr = 1'b0;
  logic [N*PB-1:0] periods;
  logic [N*AB-1:0] amps;
  logic          busy, pass_done, overrun;

  logic          ovr_clr2 = 1'b0;
  logic [N*PB-1:0] periods_unused2;
  logic [N*AB-1:0] amps_unused2;
  logic          busy_unused2, pass_done2, overrun2;

  pwl_sweep_engine #(.NUM_CHANNELS(N), .PERIOD_BITS(PB), .AMP_BITS(AB),
                     .RATE_BITS(RB), .PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ovr_clr(ovr_clr), .periods(periods), .amps(amps), .busy(busy),
    .pass_done(pass_done), .overrun(overrun));

  pwl_sweep_engine #(.NUM_CHANNELS(N), .PERIOD_BITS(PB), .AMP_BITS(AB),
                     .RATE_BITS(RB), .PRESCALE(3)) dut2 (
    .clk(clk), .rst(rst), .wr_en(1'b0), .wr_addr(4'd0), .wr_data(16'd0),
    .ovr_clr(ovr_clr2), .periods(periods_unused2), .amps(amps_unused2),
    .busy(busy_unused2), .pass_done(pass_done2), .overrun(overrun2));

  int n_checks = 0;
  int n_fail   = 0;
  int edge_k   = 0;
  int m_per[N], m_amp[N], m_psw[N], m_asw[N], m_pcnt[N], m_acnt[N];
  bit m_busy, m_pd;

  typedef struct {
    int ch;
    int rg;
    int data;
    int exp;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One sweep step from the rules: counter reaching rate steps the value with clamping
  task automatic step_field(input int v_i, input int c_i, input int s_i, input int maxv,
                            output int v_o, output int c_o, output int s_o);
    int en, dir, rate;
    en   = (s_i >> (RB + 1)) & 1;
    dir  = (s_i >> RB) & 1;
    rate = s_i & ((1 << RB) - 1);
    v_o = v_i; c_o = c_i; s_o = s_i;
    if (en == 1) begin
      if (c_i == rate) begin
        c_o = 0;
        if (dir == 0) v_o = (v_i < maxv) ? v_i + 1 : maxv;
        else          v_o = (v_i > 0) ? v_i - 1 : 0;
`ifdef PWL_SWEEP_AUTO_DISABLE_EN
        if (v_o == ((dir == 1) ? 0 : maxv)) s_o = s_i & ~(1 << (RB + 1));
`endif
      end else begin
        c_o = (c_i + 1) % (1 << RB);
      end
    end
  endtask

  // Effect of the upcoming clock edge number edge_k, from the prescaler/pass timing rules
  task automatic model_edge(input bit we, input int ch, input int rg, input int data);
    int e, r;
    bit prc;
    e   = edge_k;
    r   = e % P;
    prc = (e >= P) && (r < N);
    for (int i = 0; i < N; i++) begin
      if (we && ch == i && (rg == 0 || rg == 2)) begin
        if (rg == 0) m_per[i] = data & PMAX;
        else         m_psw[i] = data & 'h3FF;
        m_pcnt[i] = 0;
      end else if (prc && r == i) begin
        step_field(m_per[i], m_pcnt[i], m_psw[i], PMAX, m_per[i], m_pcnt[i], m_psw[i]);
      end
      if (we && ch == i && (rg == 1 || rg == 3)) begin
        if (rg == 1) m_amp[i] = data & AMAX;
        else         m_asw[i] = data & 'h3FF;
        m_acnt[i] = 0;
      end else if (prc && r == i) begin
        step_field(m_amp[i], m_acnt[i], m_asw[i], AMAX, m_amp[i], m_acnt[i], m_asw[i]);
      end
    end
    m_busy = (e >= P - 1) && (r == P - 1 || r < N - 1);
    m_pd   = (e >= P) && (r == N - 1);
  endtask

  task automatic cyc(input bit we, input int ch, input int rg, input int data, input bit clr);
    wr_en   = we;
    wr_addr = {2'(ch), 2'(rg)};
    wr_data = 16'(data);
    ovr_clr = clr;
    model_edge(we, ch, rg, data);
    @(posedge clk);
    edge_k++;
    @(negedge clk);
    wr_en   = 1'b0;
    ovr_clr = 1'b0;
  endtask

  task automatic check_model(input string tag);
    logic [63:0] ep, ea;
    ep = '0;
    ea = '0;
    for (int i = 0; i < N; i++) begin
      ep = ep | (64'(m_per[i]) << (i * PB));
      ea = ea | (64'(m_amp[i]) << (i * AB));
    end
    chk({tag, "_periods"}, 64'(periods), ep);
    chk({tag, "_amps"}, 64'(amps), ea);
    chk({tag, "_busy"}, 64'(busy), 64'(m_busy));
    chk({tag, "_pass_done"}, 64'(pass_done), 64'(m_pd));
    chk({tag, "_overrun"}, 64'(overrun), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; ovr_clr = 1'b0; ovr_clr2 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    edge_k = 0;
    for (int i = 0; i < N; i++) begin
      m_per[i] = 0; m_amp[i] = 0; m_psw[i] = 0; m_asw[i] = 0; m_pcnt[i] = 0; m_acnt[i] = 0;
    end
    m_busy = 1'b0;
    m_pd   = 1'b0;
  endtask

  task automatic wait_pass(input string tag);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 64 && !seen; t++) begin
      cyc(1'b0, 0, 0, 0, 1'b0);
      if (pass_done === 1'b1) seen = 1'b1;
    end
    chk({tag, "_pass_wait"}, 64'(seen), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int ch, rg, data, cnt, field;
    bit we, clr;

    tbl[0] = '{2, 0, 1000,     1000};
    tbl[1] = '{0, 0, 'hFFFF,   8191};
    tbl[2] = '{3, 1, 'h00FF,   63};
    tbl[3] = '{1, 1, 'h0005,   5};
    tbl[4] = '{1, 0, 'h2000,   0};
    tbl[5] = '{3, 0, 'h1234,   'h1234};
    tbl[6] = '{0, 2, 'hFDFF,   8191};
    tbl[7] = '{2, 3, 'h0000,   0};

    // Reset state
    do_reset();
    chk("reset_periods", 64'(periods), 64'd0);
    chk("reset_amps", 64'(amps), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_pass_done", 64'(pass_done), 64'd0);
    chk("reset_overrun", 64'(overrun), 64'd0);
    chk("reset_overrun2", 64'(overrun2), 64'd0);

    // Table-driven register writes
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, tbl[k].ch, tbl[k].rg, tbl[k].data, 1'b0);
      if (tbl[k].rg % 2 == 0) field = int'((periods >> (tbl[k].ch * PB)) & PMAX);
      else                    field = int'((amps >> (tbl[k].ch * AB)) & AMAX);
      chk($sformatf("tbl%0d_field", k), 64'(field), 64'(tbl[k].exp));
      check_model($sformatf("tbl%0d", k));
    end

    // Up-sweep saturation at the period limit
    do_reset();
    cyc(1'b1, 0, 0, 8189, 1'b0);
    cyc(1'b1, 0, 2, 'h200, 1'b0);
    wait_pass("sat1");
    chk("sat_after_pass1", 64'(periods[12:0]), 64'd8190);
    wait_pass("sat2");
    chk("sat_after_pass2", 64'(periods[12:0]), 64'd8191);
`ifdef PWL_SWEEP_AUTO_DISABLE_EN
    chk("sat_en_cleared", 64'(dut.psweep_r[0][RB+1]), 64'd0);
`else
    chk("sat_en_kept", 64'(dut.psweep_r[0][RB+1]), 64'd1);
`endif
    wait_pass("sat3");
    chk("sat_after_pass3", 64'(periods[12:0]), 64'd8191);
    chk("sat_counter", 64'(dut.pcnt_r[0]), 64'd0);

    // Down-sweep with rate 3 on ch1 amp
    do_reset();
    cyc(1'b1, 1, 1, 5, 1'b0);
    cyc(1'b1, 1, 3, 'h303, 1'b0);
    for (int p = 1; p <= 24; p++) begin
      wait_pass($sformatf("dn%0d", p));
      if (p == 3)  chk("dn_pass3", 64'(amps[11:6]), 64'd5);
      if (p == 4)  chk("dn_pass4", 64'(amps[11:6]), 64'd4);
      if (p == 19) chk("dn_pass19", 64'(amps[11:6]), 64'd1);
      if (p == 20) chk("dn_pass20", 64'(amps[11:6]), 64'd0);
      if (p == 24) chk("dn_pass24", 64'(amps[11:6]), 64'd0);
    end
    check_model("dn_end");

    // Write colliding with the sweep of the same field
    do_reset();
    cyc(1'b1, 1, 2, 'h200, 1'b0);
    while (edge_k < 17) cyc(1'b0, 0, 0, 0, 1'b0);
    chk("coll_before", 64'(periods[25:13]), 64'd0);
    cyc(1'b1, 1, 0, 42, 1'b0);
    chk("coll_write_wins", 64'(periods[25:13]), 64'd42);
    wait_pass("coll1");
    chk("coll_same_pass", 64'(periods[25:13]), 64'd42);
    wait_pass("coll2");
    chk("coll_next_pass", 64'(periods[25:13]), 64'd43);

    // Overrun on the PRESCALE=3 instance
    do_reset();
    while (edge_k < 7) cyc(1'b0, 0, 0, 0, 1'b0);
    chk("ovr_first_pass_done", 64'(pass_done2), 64'd1);
    chk("ovr_set", 64'(overrun2), 64'd1);
    ovr_clr2 = 1'b1;
    cyc(1'b0, 0, 0, 0, 1'b0);
    ovr_clr2 = 1'b0;
    chk("ovr_cleared", 64'(overrun2), 64'd0);
    while (edge_k < 11) cyc(1'b0, 0, 0, 0, 1'b0);
    chk("ovr_still_clear", 64'(overrun2), 64'd0);
    ovr_clr2 = 1'b1;
    cyc(1'b0, 0, 0, 0, 1'b0);
    ovr_clr2 = 1'b0;
    chk("ovr_set_beats_clr", 64'(overrun2), 64'd1);
    cnt = 0;
    while (edge_k < 60) begin
      cyc(1'b0, 0, 0, 0, 1'b0);
      if (pass_done2 === 1'b1) cnt++;
    end
    chk("ovr_pass_done_count", 64'(cnt), 64'd8);

    // Randomized traffic against the reference model
    do_reset();
    for (int t = 0; t < 800; t++) begin
      we  = ($urandom_range(0, 3) == 0);
      ch  = $urandom_range(0, 3);
      rg  = $urandom_range(0, 3);
      clr = ($urandom_range(0, 7) == 0);
      if (rg >= 2) begin
        data = int'($urandom & 'hFC00) | (($urandom_range(0, 3) != 0) ? 'h200 : 0) |
               ($urandom_range(0, 1) << 8) | $urandom_range(0, 3);
      end else if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: data = 0;
          1: data = 1;
          2: data = (rg == 0) ? PMAX - 1 : AMAX - 1;
          default: data = (rg == 0) ? PMAX : AMAX;
        endcase
      end else begin
        data = int'($urandom & 'hFFFF);
      end
      cyc(we, ch, rg, data, clr);
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
